// File: rtl/accum_ctrl_pkg.sv
// accum_ctrl_pkg: state encodings, default timing and display-mux selects shared by the accumulator sequencer
package accum_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        ADD_START = 2'd2,
        ADD_WAIT  = 2'd3
    } state_e;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_TIMEOUT         = 8;
    localparam logic [1:0] DISP_SEL_REG1 = 2'd0;
    localparam logic [1:0] DISP_SEL_ACC  = 2'd1;
    localparam logic [1:0] DISP_SEL_CNT  = 2'd2;
    localparam logic [1:0] DISP_SEL_OPND = 2'd3;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, debounce counter and rising-edge press detector
//   clk_i, rst_i : clock, asynchronous active-high reset
//   btn_i        : raw asynchronous button, high = pressed
//   press_o      : registered one-cycle press event
module btn_debounce
    import accum_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, prev_q, press_q, toggle;
    // counter runs only while the synchronised sample differs from the debounced level
    always_comb begin
        toggle  = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        level_d = level_q ^ toggle;
        cnt_d   = (sync_q[1] == level_q || toggle) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end
    assign press_o = press_q;
endmodule

// File: rtl/accum_seq_ctrl.sv
// accum_seq_ctrl: button-driven load/add/clear sequencer for the adder/accumulator datapath
//   MCLK, reset                     : clock, asynchronous active-high reset
//   btn_load, btn_add, btn_clear    : raw buttons; sw: operand switches; add_done: datapath completion
//   operand, load_en, add_start,
//   acc_clear                       : captured operand and one-cycle datapath strobes
//   busy, op_count, err, overrun,
//   state                           : status, completed-add counter, sticky flags, FSM state
module accum_seq_ctrl
    import accum_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT         = DEF_TIMEOUT,
    parameter int CNT_W           = 16
) (
    input  logic             MCLK,
    input  logic             reset,
    input  logic             btn_load,
    input  logic             btn_add,
    input  logic             btn_clear,
    input  logic [7:0]       sw,
    input  logic             add_done,
    output logic [7:0]       operand,
    output logic             load_en,
    output logic             add_start,
    output logic             acc_clear,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             err,
    output logic             overrun,
    output logic [1:0]       state
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_e           state_q, state_d;
    logic [7:0]       operand_q, operand_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             load_en_q, add_start_q, acc_clear_q, busy_q;
    logic             err_q, err_d, overrun_q, overrun_d, clr_pend_q, clr_pend_d;
    logic             load_ev, add_ev, clr_ev;
    logic             idle, clr, take_load, take_add, drop, done, timeout;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk_i(MCLK), .rst_i(reset), .btn_i(btn_load), .press_o(load_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_add (
        .clk_i(MCLK), .rst_i(reset), .btn_i(btn_add), .press_o(add_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk_i(MCLK), .rst_i(reset), .btn_i(btn_clear), .press_o(clr_ev)
    );

    always_comb begin
        idle       = state_q == IDLE;
        clr        = idle && (clr_ev || clr_pend_q);
        take_load  = idle && !clr && load_ev;
        take_add   = idle && !clr && !load_ev && add_ev;
        // a dropped load/add in the same cycle as a clear still leaves overrun set
        drop       = idle ? (clr ? (load_ev || add_ev) : (load_ev && add_ev)) : (load_ev || add_ev);
        done       = (state_q == ADD_START || state_q == ADD_WAIT) && add_done;
        timeout    = state_q == ADD_WAIT && !add_done && tmo_q == TW'(TIMEOUT - 1);
        state_d    = take_load ? LOAD :
                     take_add ? ADD_START :
                     (state_q == LOAD || done || timeout) ? IDLE :
                     (state_q == ADD_START) ? ADD_WAIT : state_q;
        clr_pend_d = idle ? 1'b0 : (clr_pend_q || clr_ev);
        operand_d  = (take_load || take_add) ? sw : operand_q;
        op_count_d = clr ? '0 : done ? op_count_q + 1'b1 : op_count_q;
        err_d      = (err_q && !clr) || timeout;
        overrun_d  = drop || (overrun_q && !clr);
        tmo_d      = (state_q == ADD_WAIT) ? tmo_q + 1'b1 : '0;
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            operand_q   <= '0;
            op_count_q  <= '0;
            tmo_q       <= '0;
            load_en_q   <= 1'b0;
            add_start_q <= 1'b0;
            acc_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
            clr_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            operand_q   <= operand_d;
            op_count_q  <= op_count_d;
            tmo_q       <= tmo_d;
            load_en_q   <= state_d == LOAD;
            add_start_q <= state_d == ADD_START;
            acc_clear_q <= clr;
            busy_q      <= state_d != IDLE;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
            clr_pend_q  <= clr_pend_d;
        end
    end

    assign operand   = operand_q;
    assign load_en   = load_en_q;
    assign add_start = add_start_q;
    assign acc_clear = acc_clear_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;
    assign err       = err_q;
    assign overrun   = overrun_q;
    assign state     = state_q;
endmodule

// File: tb/tb_accum_seq_ctrl.sv
// tb_accum_seq_ctrl: table-driven and scoreboarded check of the accumulator command sequencer
module tb_accum_seq_ctrl;
    logic       MCLK = 0, reset = 0;
    logic       btn_load = 0, btn_add = 0, btn_clear = 0;
    logic [7:0] sw = 0;
    logic       add_done_r = 0, done_f = 0;
    logic [7:0] operand;
    logic       load_en, add_start, acc_clear, busy, err, overrun;
    logic [1:0] op_count, state;

    accum_seq_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT(8), .CNT_W(2)) dut (
        .MCLK(MCLK), .reset(reset), .btn_load(btn_load), .btn_add(btn_add), .btn_clear(btn_clear),
        .sw(sw), .add_done(add_done_r | done_f), .operand(operand), .load_en(load_en),
        .add_start(add_start), .acc_clear(acc_clear), .busy(busy), .op_count(op_count),
        .err(err), .overrun(overrun), .state(state)
    );

    always #5 MCLK = ~MCLK;

    typedef struct { int kind; logic [7:0] opnd; int cyc; } exp_t;
    typedef struct { logic ld; logic [7:0] s; int dly; int cnt; logic e; int blen; } vec_t;
    exp_t exp_q[$];
    exp_t ex;
    vec_t vecs[7];
    int   n_chk = 0, n_fail = 0, cyc_n = 0, done_dly = -1;
    int   n_add_seen = 0, busy_run = 0, busy_len = 0, mk, c0, c_add;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    // raise the selected buttons at the next falling edge and hold them for hold cycles
    task automatic press(input logic l, input logic a, input logic c, input int hold, input logic [7:0] s);
        @(negedge MCLK);
        if (l || a) sw = s;
        if (l) btn_load = 1;
        if (a) btn_add = 1;
        if (c) btn_clear = 1;
        cyc(hold);
        if (l) btn_load = 0;
        if (a) btn_add = 0;
        if (c) btn_clear = 0;
    endtask

    always @(posedge MCLK) cyc_n++;

    // strobe scoreboard: kind, operand, cycle and busy are checked against the queued expectation
    always @(negedge MCLK) begin
        if (add_start) n_add_seen++;
        if (load_en || add_start || acc_clear) begin
            mk = load_en ? 0 : add_start ? 1 : 2;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_strobe: actual kind %0d required none (cycle %0d)", mk, cyc_n);
            end else begin
                ex = exp_q.pop_front();
                check("strobe_kind", mk, ex.kind);
                check("strobe_cycle", cyc_n, ex.cyc);
                check("busy_at_strobe", busy, mk != 2);
                if (mk != 2) check("strobe_operand", operand, ex.opnd);
            end
        end
    end

    always @(negedge MCLK) begin
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end

    // datapath model: answers add_start with add_done after done_dly cycles (never when negative)
    always begin
        @(negedge MCLK);
        if (add_start && done_dly >= 0) begin
            repeat (done_dly) @(negedge MCLK);
            add_done_r = 1;
            @(negedge MCLK);
            add_done_r = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 8'h02, -1, 0, 1'b0, 1};
        vecs[1] = '{1'b0, 8'h11,  3, 1, 1'b0, 4};
        vecs[2] = '{1'b0, 8'h22,  8, 2, 1'b0, 9};
        vecs[3] = '{1'b0, 8'h33,  9, 2, 1'b1, 9};
        vecs[4] = '{1'b0, 8'h44,  3, 3, 1'b1, 4};
        vecs[5] = '{1'b0, 8'h55,  0, 0, 1'b1, 1};
        vecs[6] = '{1'b0, 8'h66,  3, 1, 1'b1, 4};

        #1 reset = 1;
        #1;
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        check("rst_strobes", {load_en, add_start, acc_clear}, 0);
        check("rst_flags", {err, overrun}, 0);
        check("rst_operand", operand, 0);
        cyc(3);
        reset = 0;
        cyc(3);

        foreach (vecs[i]) begin
            done_dly = vecs[i].dly;
            c0 = cyc_n + 1;
            exp_q.push_back('{vecs[i].ld ? 0 : 1, vecs[i].s, c0 + 8});
            press(vecs[i].ld, !vecs[i].ld, 1'b0, 10, vecs[i].s);
            cyc(16);
            check($sformatf("vec%0d_op_count", i), op_count, vecs[i].cnt);
            check($sformatf("vec%0d_err", i), err, vecs[i].e);
            check($sformatf("vec%0d_state", i), state, 0);
            check($sformatf("vec%0d_operand", i), operand, vecs[i].s);
            check($sformatf("vec%0d_busy_len", i), busy_len, vecs[i].blen);
        end
        done_dly = -1;

        done_f = 1;
        cyc(1);
        done_f = 0;
        cyc(2);
        check("idle_done_ignored", op_count, 1);

        c_add = n_add_seen;
        press(1'b0, 1'b1, 1'b0, 3, 8'hEE);
        cyc(15);
        check("glitch_no_add", n_add_seen, c_add);
        check("glitch_overrun", overrun, 0);
        check("glitch_operand", operand, 8'h66);

        c0 = cyc_n + 1;
        exp_q.push_back('{0, 8'h77, c0 + 8});
        press(1'b1, 1'b1, 1'b0, 10, 8'h77);
        cyc(16);
        check("prio_overrun", overrun, 1);
        check("prio_no_add", n_add_seen, c_add);
        check("prio_operand", operand, 8'h77);

        c0 = cyc_n + 1;
        exp_q.push_back('{2, 8'h00, c0 + 8});
        press(1'b0, 1'b0, 1'b1, 10, 8'h00);
        cyc(16);
        check("clear_op_count", op_count, 0);
        check("clear_err", err, 0);
        check("clear_overrun", overrun, 0);
        check("clear_operand", operand, 8'h77);

        c0 = cyc_n + 1;
        exp_q.push_back('{1, 8'h5A, c0 + 8});
        press(1'b0, 1'b1, 1'b0, 4, 8'h5A);
        cyc(3);
        press(1'b0, 1'b1, 1'b0, 5, 8'hA5);
        cyc(16);
        check("drop_overrun", overrun, 1);
        check("drop_one_add", n_add_seen, c_add + 1);
        check("drop_err", err, 1);
        check("drop_operand", operand, 8'h5A);
        check("drop_busy_len", busy_len, 9);

        c0 = cyc_n + 1;
        exp_q.push_back('{1, 8'h3C, c0 + 8});
        press(1'b0, 1'b1, 1'b0, 4, 8'h3C);
        cyc(6);
        check("pre_reset_state", state, 3);
        #2 reset = 1;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flags", {err, overrun}, 0);
        check("mid_rst_operand", operand, 0);
        check("mid_rst_strobes", {load_en, add_start, acc_clear}, 0);
        cyc(2);
        reset = 0;
        c_add = n_add_seen;
        cyc(12);
        check("post_rst_no_add", n_add_seen, c_add);
        check("post_rst_busy", busy, 0);

        c0 = cyc_n + 1;
        exp_q.push_back('{1, 8'h81, c0 + 8});
        exp_q.push_back('{2, 8'h00, c0 + 18});
        fork
            press(1'b0, 1'b1, 1'b0, 10, 8'h81);
            begin
                cyc(2);
                press(1'b0, 1'b0, 1'b1, 10, 8'h00);
            end
        join
        cyc(16);
        check("pend_clr_err", err, 0);
        check("pend_clr_overrun", overrun, 0);
        check("pend_clr_op_count", op_count, 0);
        check("pend_clr_state", state, 0);
        check("pend_clr_busy_len", busy_len, 9);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
